// File: rtl/rom_select_ctrl_pkg.sv
// Shared types and helpers for the ROM select controller: FSM state encoding,
// a constant-safe clog2, and the lowest-pressed-button encoder.
package rom_select_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HELD    = 2'd1,
        PENDING = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    // Lowest-numbered set bit wins; returns 0 for an empty vector.
    function automatic logic [2:0] lowest_set(input logic [7:0] vec);
        logic [2:0] enc;
        enc = '0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) enc = 3'(i);
        end
        return enc;
    endfunction

endpackage

// File: rtl/rom_select_ctrl_if.sv
// Button/loader/reload bundle between the board-level logic and the ROM select controller.
interface rom_select_ctrl_if #(
    parameter int NUM_BTNS = 4,
    parameter int INDEX_W  = 4
);
    logic [NUM_BTNS-1:0] btn_raw;
    logic                shift_raw;
    logic                load_busy;
    logic                reload;
    logic [INDEX_W-1:0]  index;
    logic [NUM_BTNS:0]   btn_state;

    modport master (
        output btn_raw, shift_raw, load_busy,
        input  reload, index, btn_state
    );

    modport slave (
        input  btn_raw, shift_raw, load_busy,
        output reload, index, btn_state
    );
endinterface

// File: rtl/rom_select_ctrl_btn_debounce.sv
// One button bit: 2-FF synchroniser, polarity normalisation and a stability counter.
module btn_debounce
    import rom_select_pkg::*;
#(
    parameter int DEBOUNCE_COUNT = 50000,
    parameter bit ACTIVE_LOW     = 1'b1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic pressed
);
    localparam int   CNT_W         = clog2(DEBOUNCE_COUNT + 1);
    localparam logic RELEASED_PIN  = ACTIVE_LOW ? 1'b1 : 1'b0;

    logic             sync1_reg;
    logic             sync2_reg;
    logic             db_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             level;

    assign level = ACTIVE_LOW ? ~sync2_reg : sync2_reg;

    // Synchronisers reset to the released pin level so reset release never looks like a press.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= RELEASED_PIN;
            sync2_reg <= RELEASED_PIN;
            db_reg    <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            if (level == db_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_W'(DEBOUNCE_COUNT - 1)) begin
                db_reg  <= level;
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign pressed = db_reg;
endmodule

// File: rtl/rom_select_ctrl.sv
// ROM slot selector: debounced select/shift buttons pick a slot while held and
// issue a single reload pulse on full release, deferred while the loader is busy.
module rom_select_ctrl
    import rom_select_pkg::*;
#(
    parameter int NUM_BTNS       = 4,
    parameter int INDEX_W        = 4,
    parameter int DEBOUNCE_COUNT = 50000,
    parameter bit ACTIVE_LOW     = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    rom_select_ctrl_if.slave bus
);
    localparam int ENC_BITS = clog2(NUM_BTNS);

    logic [NUM_BTNS:0]  raw_vec;
    logic [NUM_BTNS:0]  db_vec;
    logic               any_sel;
    logic [INDEX_W-1:0] cand_now;

    state_t             state_reg, state_next;
    logic [INDEX_W-1:0] cand_reg, cand_next;
    logic [INDEX_W-1:0] index_reg, index_next;
    logic               reload_reg, reload_next;

    assign raw_vec = {bus.shift_raw, bus.btn_raw};

    // Bit NUM_BTNS is the shift button; the rest are select buttons.
    generate
        for (genvar gi = 0; gi <= NUM_BTNS; gi++) begin : g_db
            btn_debounce #(
                .DEBOUNCE_COUNT(DEBOUNCE_COUNT),
                .ACTIVE_LOW    (ACTIVE_LOW)
            ) u_db (
                .clock  (clock),
                .reset_n(reset_n),
                .raw    (raw_vec[gi]),
                .pressed(db_vec[gi])
            );
        end
    endgenerate

    assign any_sel = |db_vec[NUM_BTNS-1:0];

    // Shift sits directly above the encoded button number.
    always_comb begin
        cand_now           = INDEX_W'(lowest_set(8'(db_vec[NUM_BTNS-1:0])));
        cand_now[ENC_BITS] = db_vec[NUM_BTNS];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            cand_reg   <= '0;
            index_reg  <= '0;
            reload_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cand_reg   <= cand_next;
            index_reg  <= index_next;
            reload_reg <= reload_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_sel) state_next = HELD;
            HELD:    if (!any_sel) state_next = bus.load_busy ? PENDING : IDLE;
            PENDING: if (!bus.load_busy) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cand_next   = cand_reg;
        index_next  = index_reg;
        reload_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (any_sel) cand_next = cand_now;
            end
            HELD: begin
                if (any_sel) begin
                    cand_next = cand_now;
                end else if (!bus.load_busy) begin
                    reload_next = 1'b1;
                    index_next  = cand_reg;
                end
            end
            PENDING: begin
                if (!bus.load_busy) begin
                    reload_next = 1'b1;
                    index_next  = cand_reg;
                end
            end
            default: ;
        endcase
    end

    assign bus.reload    = reload_reg;
    assign bus.index     = index_reg;
    assign bus.btn_state = db_vec;
endmodule

// File: tb/tb_rom_select_ctrl.sv
// Directed bench for rom_select_ctrl with DEBOUNCE_COUNT=8, four active-low select buttons.
module tb_rom_select_ctrl;
    import rom_select_pkg::*;

    logic clock;
    logic reset_n;

    int total_cnt  = 0;
    int pass_cnt   = 0;
    int reload_cnt = 0;
    int consec_cnt = 0;
    int base;
    logic prev_reload = 1'b0;

    rom_select_ctrl_if #(.NUM_BTNS(4), .INDEX_W(4)) bus ();

    rom_select_ctrl #(
        .NUM_BTNS      (4),
        .INDEX_W       (4),
        .DEBOUNCE_COUNT(8),
        .ACTIVE_LOW    (1'b1)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        #1;
        if (bus.reload === 1'b1) begin
            reload_cnt = reload_cnt + 1;
            if (prev_reload) consec_cnt = consec_cnt + 1;
        end
        prev_reload = (bus.reload === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        $display("check %-22s observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.btn_raw   = 4'hF;
        bus.shift_raw = 1'b1;
        bus.load_busy = 1'b0;
        tick(3);
        check("rst_reload", 32'(bus.reload), 32'd0);
        check("rst_index", 32'(bus.index), 32'd0);
        check("rst_btn_state", 32'(bus.btn_state), 32'd0);
        reset_n = 1'b1;

        // Idle for 100 cycles with all pins released
        base = reload_cnt;
        tick(100);
        check("idle_reloads", 32'(reload_cnt - base), 32'd0);
        check("idle_index", 32'(bus.index), 32'd0);
        check("idle_btn_state", 32'(bus.btn_state), 32'd0);

        // Button 2: press 50 cycles, debounce latency 10 edges
        base = reload_cnt;
        bus.btn_raw = 4'b1011;
        tick(9);
        check("b2_rise_early", 32'(bus.btn_state), 32'd0);
        tick(1);
        check("b2_rise", 32'(bus.btn_state), 32'h04);
        tick(40);
        bus.btn_raw = 4'hF;
        tick(9);
        check("b2_fall_early", 32'(bus.btn_state), 32'h04);
        tick(1);
        check("b2_fall", 32'(bus.btn_state), 32'd0);
        check("b2_no_reload_yet", 32'(bus.reload), 32'd0);
        tick(1);
        check("b2_reload", 32'(bus.reload), 32'd1);
        check("b2_index", 32'(bus.index), 32'h2);
        tick(1);
        check("b2_reload_drop", 32'(bus.reload), 32'd0);
        tick(20);
        check("b2_reload_count", 32'(reload_cnt - base), 32'd1);

        // Shift + button 1, button released first so shift is still held
        base = reload_cnt;
        bus.btn_raw = 4'b1101;
        bus.shift_raw = 1'b0;
        tick(15);
        check("s1_btn_state", 32'(bus.btn_state), 32'h12);
        bus.btn_raw = 4'hF;
        tick(15);
        check("s1_index", 32'(bus.index), 32'h5);
        check("s1_reload_count", 32'(reload_cnt - base), 32'd1);
        bus.shift_raw = 1'b1;
        tick(15);
        check("s1_shift_only", 32'(reload_cnt - base), 32'd1);
        check("s1_btn_state_end", 32'(bus.btn_state), 32'd0);

        // Shift released before button 1: index carries no shift bit
        base = reload_cnt;
        bus.btn_raw = 4'b1101;
        bus.shift_raw = 1'b0;
        tick(15);
        bus.shift_raw = 1'b1;
        tick(15);
        bus.btn_raw = 4'hF;
        tick(15);
        check("s2_index", 32'(bus.index), 32'h1);
        check("s2_reload_count", 32'(reload_cnt - base), 32'd1);

        // Button 3 glitches of 5 cycles
        base = reload_cnt;
        for (int g = 0; g < 4; g++) begin
            bus.btn_raw = 4'b0111;
            tick(5);
            bus.btn_raw = 4'hF;
            tick(10);
            check("glitch_btn_state", 32'(bus.btn_state), 32'd0);
        end
        check("glitch_reloads", 32'(reload_cnt - base), 32'd0);

        // Loader busy: selection pends, later presses ignored
        base = reload_cnt;
        bus.load_busy = 1'b1;
        bus.btn_raw = 4'b1110;
        tick(15);
        bus.btn_raw = 4'hF;
        tick(15);
        check("busy_no_reload", 32'(reload_cnt - base), 32'd0);
        bus.btn_raw = 4'b0111;
        tick(15);
        check("busy_b3_state", 32'(bus.btn_state), 32'h08);
        bus.btn_raw = 4'hF;
        tick(15);
        tick(140);
        check("busy_still_none", 32'(reload_cnt - base), 32'd0);
        check("busy_index_held", 32'(bus.index), 32'h1);
        bus.load_busy = 1'b0;
        tick(1);
        check("busy_reload", 32'(bus.reload), 32'd1);
        check("busy_index", 32'(bus.index), 32'h0);
        tick(1);
        check("busy_reload_drop", 32'(bus.reload), 32'd0);
        tick(20);
        check("busy_reload_count", 32'(reload_cnt - base), 32'd1);

        // Set a nonzero index, then reset in the middle of HELD
        bus.btn_raw = 4'b1011;
        tick(15);
        bus.btn_raw = 4'hF;
        tick(15);
        check("pre_rst_index", 32'(bus.index), 32'h2);
        base = reload_cnt;
        bus.btn_raw = 4'b1101;
        tick(15);
        reset_n = 1'b0;
        tick(3);
        check("mid_rst_index", 32'(bus.index), 32'd0);
        check("mid_rst_btn_state", 32'(bus.btn_state), 32'd0);
        bus.btn_raw = 4'hF;
        tick(3);
        reset_n = 1'b1;
        tick(30);
        check("post_rst_reloads", 32'(reload_cnt - base), 32'd0);
        check("post_rst_index", 32'(bus.index), 32'd0);
        check("post_rst_btn_state", 32'(bus.btn_state), 32'd0);

        check("no_back_to_back", 32'(consec_cnt), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/rom_select_ctrl.md
Name: rom_select_ctrl

Overview:
Parametrised successor to the single-button reload logic on the top level. Takes NUM_BTNS select buttons plus one shift button, synchronises and debounces each one, and tracks the chosen ROM slot while buttons are held. On full release it latches a ROM index and issues a one-cycle reload pulse to main_mem. If the loader is busy, the pulse is held off until it is idle.

Parameters:
NUM_BTNS, 4, number of select buttons (1..8)
INDEX_W, 4, width of index output; must be ≥ clog2(NUM_BTNS)+1
DEBOUNCE_COUNT, 50000, consecutive stable cycles needed to accept a level change (≥1)
ACTIVE_LOW, 1, 1 = raw pins read 0 when pressed (pull-up buttons)

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
btn_raw  in  NUM_BTNS  raw select-button pins, asynchronous
shift_raw  in  1  raw shift-button pin, asynchronous
load_busy  in  1  high while main_mem is loading (i.e. !load_done)
reload  out  1  one-cycle reload request
index  out  INDEX_W  ROM slot = {shift, encoded button}, zero-extended
btn_state  out  NUM_BTNS+1  debounced pressed levels {shift, btn}, 1 = pressed

Behaviour:
- Reset (async assert, sync release via clock edge): reload=0, index=0, btn_state=0, all counters 0, FSM=IDLE, candidate=0.
- Input path: 2-FF synchroniser per bit. Polarity is normalised after the synchroniser (pressed=1 when ACTIVE_LOW=1 and pin=0).
- Debounce, per bit:
  - Counter clears whenever the synced value equals the debounced value.
  - Otherwise it increments. On the cycle the count reaches DEBOUNCE_COUNT-1 and the values still differ, the debounced value takes the synced value and the counter clears.
  - Raw edge to btn_state change = 2 + DEBOUNCE_COUNT cycles.
  - A glitch shorter than DEBOUNCE_COUNT synced cycles produces no change.
  - Counter width = clog2(DEBOUNCE_COUNT+1).
- Candidate encoding: the lowest-numbered pressed select button wins. candidate = {shift_db, enc}, where enc is a clog2(NUM_BTNS)-bit binary index, then zero-extended or packed to INDEX_W.
- FSM:
  - IDLE: if any select button is debounced-pressed, load candidate and go to HELD. Shift alone does nothing.
  - HELD: each cycle with any select pressed, reload candidate (shift is re-sampled, so last value before release wins). When all select buttons are released:
    - load_busy=0: reload<=1, index<=candidate, go to IDLE.
    - load_busy=1: go to PENDING.
  - PENDING: new presses are ignored; candidate is frozen. When load_busy=0: reload<=1, index<=candidate, go to IDLE.
- reload and index are registered and update on the same edge. reload is high exactly one cycle per selection and is never asserted in two consecutive cycles.
- index holds its value until the next selection.
- Button still held on return to IDLE: enters HELD on the next cycle. This is a new selection and needs a release.
- Shift released before select buttons: the index uses shift as sampled on the last HELD cycle with a select pressed.
- Reset mid-HELD or mid-PENDING: the selection is discarded and no reload is issued.

Decomposition:
- Package rom_select_pkg holds:
  - state enum {IDLE, HELD, PENDING}, encoded as 2 bits;
  - function clog2;
  - function for lowest-set-bit encode.
- One sub-module, btn_debounce, is instantiated NUM_BTNS+1 times. It contains the synchroniser, polarity and counter for one bit, with parameters DEBOUNCE_COUNT and ACTIVE_LOW.

Test Plan:
(Simulation parameters: DEBOUNCE_COUNT=8, NUM_BTNS=4, INDEX_W=4, ACTIVE_LOW=1.)
- Reset release, all pins high, 100 cycles → reload never asserts, index=0, btn_state=0.
- btn_raw[2] low for 50 cycles then high, load_busy=0 → btn_state[2] rises 10 cycles after the falling edge. reload pulses exactly once, one cycle after btn_state[2] falls. index=4'b0010.
- shift_raw and btn_raw[1] low together, shift_raw released last, then btn_raw[1] released → index=4'b0101, single reload pulse.
- btn_raw[3] toggling with 5-cycle-low glitches → btn_state stays 0, no reload.
- btn_raw[0] press and release while load_busy=1 for 200 more cycles, pressing btn_raw[3] meanwhile → no reload until load_busy falls. Then reload fires the next cycle with index=0. The btn_raw[3] press is ignored if released during PENDING.
- reset_n asserted mid-HELD with btn_raw[1] pressed, then released after the button is released → reload never asserts, index=0.
